t10_multitap_keypad: RTL
========================

// Module: t10_multitap_keypad
// PURPOSE
//  Parametrised multi-tap keypad decoder for the 4x4 matrix keypad: turns debounced key strobes into ASCII letters
//  (phone layout) and control events, and queues them in a DEPTH-entry output FIFO with valid/ready handshake.
//  Adds inactivity auto-commit, a configurable strobe synchroniser, optional lowercase output, overflow reporting
//  and a post-game lock. Sits between the keypad scanner and the game/word-compare logic.
// PARAMETERS
//  SYNC_STAGES     2           strobe synchroniser flops (>=2)
//  TIMEOUT_CYCLES  25_000_000  idle cycles after last letter tap before pending letter auto-commits (>=2)
//  DEPTH           4           output FIFO entries (power of two, >=2)
//  LOWERCASE       0           1: letters emitted as a-z (code +8'd32)
// PORTS
//  clk         in   1   system clock
//  nRst        in   1   asynchronous active-low reset
//  strobe      in   1   key-press strobe from scanner (async, debounced)
//  cur_key     in   8   {row[3:0],col[3:0]} one-hot each; row[3]=R0, col[3]=C0
//  char_ready  in   1   consumer accepts char_data this cycle
//  char_valid  out  1   FIFO non-empty
//  char_data   out  8   FIFO head: ASCII letter, or 8'h00 = end-of-word marker
//  preview     out  8   letter currently selected (pending), '_' 8'h5F idle, '-' 8'h2D locked
//  fifo_count  out  $clog2(DEPTH)+1  entries held
//  overflow    out  1   sticky: a push was dropped because FIFO full
//  word_end    out  1   one-cycle pulse when end-of-word marker is pushed
//  game_end    out  1   one-cycle pulse on game-end key
// BEHAVIOUR
//  Reset (async): state IDLE, preview 8'h5F, FIFO empty, char_valid 0, char_data 8'h00, fifo_count 0, overflow 0,
//   word_end 0, game_end 0, tap index 0, timeout counter 0, synchroniser cleared. nRst mid-operation discards all.
//  Edge: strobe passes SYNC_STAGES flops + 1 history flop; press event E = sync & ~hist. cur_key sampled in cycle E;
//   all resulting register updates visible the cycle after E. No event if cur_key row or col not exactly one-hot.
//  Key map: R0C1 ABC, R0C2 DEF, R1C0 GHI, R1C1 JKL, R1C2 MNO, R2C0 PQRS, R2C1 TUV, R2C2 WXYZ.
//   Commands: R3C0 submit-letter, R3C1 clear, R3C2 submit-word, R2C3 game-end. R0C0,R0C3,R1C3,R3C3 ignored.
//  Letter = base + tap; tap wraps 2->0 (3-letter keys) or 3->0 (PQRS,WXYZ). +32 when LOWERCASE.
//  States: IDLE, PENDING, WORD_FLUSH, LOCKED.
//   IDLE   letter key -> PENDING, tap 0, preview=letter, timer 0. submit-letter: no action. submit-word -> WORD_FLUSH.
//   PENDING same key -> tap+1 (wrap), timer 0. different letter key -> push pending, new key tap 0, timer 0.
//          submit-letter -> push pending, IDLE. timer reaches TIMEOUT_CYCLES-1 with no event -> push pending, IDLE.
//          submit-word -> push pending, WORD_FLUSH.
//   WORD_FLUSH (1 cycle) push 8'h00, pulse word_end, -> IDLE; events in this cycle ignored.
//   Any non-LOCKED state: clear -> discard pending, overflow<=0, IDLE. game-end -> discard pending, pulse game_end,
//          LOCKED. LOCKED: preview 8'h2D, all events ignored until reset; FIFO still drains.
//  preview returns to 8'h5F whenever state enters IDLE; pushes never alter preview except as stated.
//  FIFO: first-word-fall-through; pop when char_valid & char_ready. Max one push per cycle. Push while full and no pop
//   -> dropped, overflow<=1 (push+pop same cycle when full: accepted). Pointers wrap mod DEPTH.
//  Timer counts only in PENDING, saturates; width $clog2(TIMEOUT_CYCLES).
// TESTING (TIMEOUT_CYCLES=16, DEPTH=4 unless noted)
//  1 tap 8'h84 x3, then 8'h18 -> preview 'A','B','C'; FIFO gets 8'h43; preview back to 8'h5F.
//  2 tap 8'h28 x5, idle -> preview cycles P,Q,R,S,P; 16 cycles after last tap 8'h50 pushed, state IDLE.
//  3 tap 8'h48 then 8'h44 -> 8'h47 'G' pushed on 2nd press, preview 8'h4A 'J'; LOWERCASE=1 pushes 8'h67.
//  4 char_ready=0, commit 5 letters -> fifo_count 4, 5th dropped, overflow=1; char_ready=1 pops 4 in order; clear resets overflow.
//  5 tap 8'h24, press 8'h12 -> FIFO gets 8'h54 then 8'h00 next cycle, word_end 1-cycle pulse coincident with 8'h00 push.
//  6 pending 'M', press 8'h21 -> game_end pulse, nothing pushed, preview 8'h2D, later presses ignored; nRst -> reset values.

Source files
------------

// File: rtl/t10_multitap_keypad.sv
// Multi-tap phone-style keypad decoder: turns key strobes into ASCII letters and
// word/game events, queued in a small first-word-fall-through FIFO.
module t10_multitap_keypad #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 25_000_000,
   parameter int DEPTH          = 4,
   parameter int LOWERCASE      = 0
) (
   input  logic                     clk,
   input  logic                     nRst,
   input  logic                     strobe,
   input  logic [7:0]               cur_key,
   input  logic                     char_ready,
   output logic                     char_valid,
   output logic [7:0]               char_data,
   output logic [7:0]               preview,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic                     word_end,
   output logic                     game_end
);
   // state      | meaning
   // IDLE       | no letter selected, preview '_'
   // PENDING    | letter selected, tapping cycles it, timer runs
   // WORD_FLUSH | one cycle: push end-of-word marker 8'h00
   // LOCKED     | game over, all keys ignored until reset
   typedef enum logic [1:0] {IDLE, PENDING, WORD_FLUSH, LOCKED} state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] CASE_OFS = (LOWERCASE != 0) ? 8'd32 : 8'd0;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   press;

   logic       key_letter, key_sub_letter, key_clear, key_sub_word, key_game;
   logic [2:0] key_idx;
   logic       ev_letter, ev_sub_letter, ev_clear, ev_sub_word, ev_game;

   logic [2:0]    pend_key;
   logic [1:0]    tap, tap_max;
   logic [TW-1:0] timer_q;
   logic [7:0]    pend_letter;

   logic       push, load, tap_inc, clr_ovf, word_end_d, game_end_d;
   logic [7:0] push_data;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          full, pop, push_ok;

   function automatic logic [7:0] base_of(input logic [2:0] k);
      case (k)
         3'd0:    base_of = 8'h41;
         3'd1:    base_of = 8'h44;
         3'd2:    base_of = 8'h47;
         3'd3:    base_of = 8'h4A;
         3'd4:    base_of = 8'h4D;
         3'd5:    base_of = 8'h50;
         3'd6:    base_of = 8'h54;
         default: base_of = 8'h57;
      endcase
   endfunction

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign press = sync_q[SYNC_STAGES-1] & ~hist_q;

   // Matching full codes rejects anything whose row or column is not one-hot.
   always_comb begin
      key_letter     = 1'b0;
      key_sub_letter = 1'b0;
      key_clear      = 1'b0;
      key_sub_word   = 1'b0;
      key_game       = 1'b0;
      key_idx        = 3'd0;
      case (cur_key)
         8'h84:   begin key_letter = 1'b1; key_idx = 3'd0; end
         8'h82:   begin key_letter = 1'b1; key_idx = 3'd1; end
         8'h48:   begin key_letter = 1'b1; key_idx = 3'd2; end
         8'h44:   begin key_letter = 1'b1; key_idx = 3'd3; end
         8'h42:   begin key_letter = 1'b1; key_idx = 3'd4; end
         8'h28:   begin key_letter = 1'b1; key_idx = 3'd5; end
         8'h24:   begin key_letter = 1'b1; key_idx = 3'd6; end
         8'h22:   begin key_letter = 1'b1; key_idx = 3'd7; end
         8'h18:   key_sub_letter = 1'b1;
         8'h14:   key_clear      = 1'b1;
         8'h12:   key_sub_word   = 1'b1;
         8'h21:   key_game       = 1'b1;
         default: ;
      endcase
   end

   assign ev_letter     = press & key_letter;
   assign ev_sub_letter = press & key_sub_letter;
   assign ev_clear      = press & key_clear;
   assign ev_sub_word   = press & key_sub_word;
   assign ev_game       = press & key_game;

   assign tap_max     = (pend_key == 3'd5 || pend_key == 3'd7) ? 2'd3 : 2'd2;
   assign pend_letter = base_of(pend_key) + {6'd0, tap} + CASE_OFS;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      push_data  = pend_letter;
      load       = 1'b0;
      tap_inc    = 1'b0;
      clr_ovf    = 1'b0;
      word_end_d = 1'b0;
      game_end_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev_letter) begin
               load    = 1'b1;
               state_d = PENDING;
            end else if (ev_sub_word) begin
               state_d = WORD_FLUSH;
            end
         end
         PENDING: begin
            if (ev_letter) begin
               if (key_idx == pend_key) begin
                  tap_inc = 1'b1;
               end else begin
                  push = 1'b1;
                  load = 1'b1;
               end
            end else if (ev_sub_letter) begin
               push    = 1'b1;
               state_d = IDLE;
            end else if (ev_sub_word) begin
               push    = 1'b1;
               state_d = WORD_FLUSH;
            end else if (!ev_clear && !ev_game && timer_q == TMAX) begin
               push    = 1'b1;
               state_d = IDLE;
            end
         end
         WORD_FLUSH: begin
            push       = 1'b1;
            push_data  = 8'h00;
            word_end_d = 1'b1;
            state_d    = IDLE;
         end
         default: ;
      endcase
      if (state_q == IDLE || state_q == PENDING) begin
         if (ev_clear) begin
            clr_ovf = 1'b1;
            state_d = IDLE;
         end else if (ev_game) begin
            game_end_d = 1'b1;
            state_d    = LOCKED;
         end
      end
   end

   always_comb begin
      case (state_q)
         PENDING: preview = pend_letter;
         LOCKED:  preview = 8'h2D;
         default: preview = 8'h5F;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         pend_key <= 3'd0;
         tap      <= 2'd0;
         timer_q  <= '0;
         word_end <= 1'b0;
         game_end <= 1'b0;
      end else begin
         word_end <= word_end_d;
         game_end <= game_end_d;
         if (load) begin
            pend_key <= key_idx;
            tap      <= 2'd0;
         end else if (tap_inc) begin
            tap <= (tap == tap_max) ? 2'd0 : tap + 2'd1;
         end
         if (state_q != PENDING || ev_letter) timer_q <= '0;
         else if (timer_q != TMAX)            timer_q <= timer_q + 1'b1;
      end
   end

   assign char_valid = (count != '0);
   assign full       = (count == CW'(DEPTH));
   assign pop        = char_valid & char_ready;
   assign push_ok    = push & (~full | pop);
   assign char_data  = char_valid ? mem[rptr] : 8'h00;
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (clr_ovf)                     overflow <= 1'b0;
         else if (push & full & ~pop)     overflow <= 1'b1;
      end
   end

endmodule
